conv_1d_stream: RTL and testbench

//  Streaming 1-D signed FIR convolution over image lines; successor of the static-array convolver.

---
 rtl/conv_1d_stream.sv | 124 ++++++++++++
 tb/tb_conv_1d_stream.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/conv_1d_stream.sv
// conv_1d_stream: streaming signed 1-D FIR over image lines with zero/replicate padding,
// runtime-loadable taps, rounding and saturation; one pixel in and one pixel out per beat.
module conv_1d_stream #(
    parameter int DW      = 8,
    parameter int CW      = 8,
    parameter int K       = 3,
    parameter int OW      = 8,
    parameter int SHIFT   = 0,
    parameter int MAX_LEN = 640
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                coef_we,
    input  logic [((K > 1) ? $clog2(K) : 1)-1:0] coef_idx,
    input  logic signed [CW-1:0]                coef_data,
    input  logic                                pad_mode,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic signed [DW-1:0]                in_data,
    input  logic                                in_last,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic signed [OW-1:0]                out_data,
    output logic                                out_last,
    output logic                                busy
);
    localparam int H  = (K - 1) / 2;
    localparam int AW = DW + CW + $clog2(K);
    localparam int PW = $clog2(MAX_LEN + K);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2;
    localparam logic [PW-1:0] PMAX = PW'(MAX_LEN + K - 1);
    localparam logic signed [AW-1:0] RND  = (SHIFT > 0) ? (AW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
    localparam logic signed [AW-1:0] OMAX = AW'((2 ** (OW - 1)) - 1);
    localparam logic signed [AW-1:0] OMIN = AW'(-(2 ** (OW - 1)));

    logic [1:0]           state_q, state_d;
    logic signed [DW-1:0] win_q [K], win_d [K];
    logic signed [CW-1:0] coef_q [K], coef_d [K];
    logic [PW-1:0]        pos_q, pos_d, cnt_q, cnt_d;
    logic signed [DW-1:0] last_q, last_d, ins;
    logic                 pad_q, pad_d;
    logic                 ov_q, ov_d, ol_q, ol_d;
    logic signed [OW-1:0] od_q, od_d, sat;
    logic signed [AW-1:0] acc, sh;
    logic                 adv, accept, first, step, emit, fin;

    always_comb begin
        adv      = !ov_q || out_ready;
        in_ready = adv && state_q != FLUSH;
        accept   = in_valid && in_ready;
        first    = accept && state_q == IDLE;
        step     = adv && (accept || state_q == FLUSH);
        state_d  = state_q;
        win_d    = win_q;
        coef_d   = coef_q;
        cnt_d    = cnt_q;
        ov_d     = ov_q;
        od_d     = od_q;
        ol_d     = ol_q;
        pad_d    = first ? pad_mode : pad_q;
        last_d   = accept ? in_data : last_q;
        ins      = state_q == FLUSH ? (pad_q ? last_q : '0) : in_data;
        // The first beat of a line preloads the history with its pad value, so no stale pixels leak in.
        if (step) begin
            for (int j = 0; j < K - 1; j++) win_d[j] = first ? (pad_mode ? in_data : '0) : win_q[j+1];
            win_d[K-1] = ins;
        end
        pos_d = first ? '0 : (step && pos_q != PMAX) ? pos_q + 1'b1 : pos_q;
        if (accept && in_last) begin
            state_d = (H == 0) ? IDLE : FLUSH;
            cnt_d   = PW'(H);
        end else if (first) begin
            state_d = RUN;
        end else if (step && state_q == FLUSH) begin
            cnt_d   = cnt_q - 1'b1;
            state_d = cnt_q == PW'(1) ? IDLE : FLUSH;
        end
        if (coef_we && state_q == IDLE && !accept && 32'(coef_idx) < K) coef_d[coef_idx] = coef_data;
        acc = '0;
        for (int j = 0; j < K; j++) acc = acc + AW'(win_d[j]) * AW'(coef_q[j]);
        sh   = (acc + RND) >>> SHIFT;
        sat  = sh > OMAX ? OW'(OMAX) : sh < OMIN ? OW'(OMIN) : sh[OW-1:0];
        emit = step && pos_d >= PW'(H);
        fin  = step && (state_q == FLUSH ? cnt_q == PW'(1) : (in_last && H == 0));
        if (adv) ov_d = emit;
        if (emit) begin
            od_d = sat;
            ol_d = fin;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            for (int j = 0; j < K; j++) begin
                win_q[j]  <= '0;
                coef_q[j] <= '0;
            end
            pos_q  <= '0;
            cnt_q  <= '0;
            last_q <= '0;
            pad_q  <= 1'b0;
            ov_q   <= 1'b0;
            od_q   <= '0;
            ol_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            coef_q  <= coef_d;
            pos_q   <= pos_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            pad_q   <= pad_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
            ol_q    <= ol_d;
        end
    end

    assign out_valid = ov_q;
    assign out_data  = od_q;
    assign out_last  = ol_q;
    assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_conv_1d_stream.sv
// tb_conv_1d_stream: directed and randomized lines against a padded-convolution reference model.
module tb_conv_1d_stream;
    logic       clk = 1'b0;
    logic       rst, coef_we, pad_mode, in_valid, in_last, out_ready;
    logic [1:0] coef_idx;
    logic [7:0] coef_data, in_data, out_data;
    logic       in_ready, out_valid, out_last, busy;
    int compared = 0, mismatched = 0;
    int mc [3];
    int xs [64];

    conv_1d_stream dut (
        .clk(clk), .rst(rst), .coef_we(coef_we), .coef_idx(coef_idx), .coef_data(coef_data),
        .pad_mode(pad_mode), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int model(input int n, input int len, input int pad);
        int acc = 0;
        for (int j = 0; j < 3; j++) begin
            int i = n + j - 1;
            int v = (i < 0) ? (pad != 0 ? xs[0] : 0) : (i >= len) ? (pad != 0 ? xs[len-1] : 0) : xs[i];
            acc += mc[j] * v;
        end
        return acc > 127 ? 127 : acc < -128 ? -128 : acc;
    endfunction

    task automatic write_coef(input int idx, input int val);
        @(negedge clk);
        coef_we = 1'b1;
        coef_idx = 2'(idx);
        coef_data = 8'(val);
        @(negedge clk);
        coef_we = 1'b0;
        if (idx < 3) mc[idx] = val;
    endtask

    task automatic run_line(input int len, input int pad, input int rp, input bit wr_busy);
        int sent = 0, got = 0, cyc = 0;
        bit held = 0;
        logic [7:0] hd = '0;
        while (got < len && cyc < 500) begin
            @(negedge clk);
            cyc++;
            out_ready = (rp == 0) ? 1'b1 : ($urandom_range(99) >= rp);
            in_valid  = sent < len && (rp == 0 || $urandom_range(3) != 0);
            in_data   = 8'(xs[sent < len ? sent : 0]);
            in_last   = sent == len - 1;
            pad_mode  = (sent == 0) ? pad[0] : !pad[0];
            coef_we   = wr_busy && (busy || (sent == 0 && in_valid && rp == 0));
            coef_idx  = 2'd0;
            coef_data = 8'd77;
            #1;
            if (held) check("hold_data", out_data, hd);
            if (out_valid && !out_ready) check("in_ready_hold", in_ready, 0);
            if (out_valid && out_ready) begin
                check("data", $signed(out_data), model(got, len, pad));
                check("last", out_last, got == len - 1);
                got++;
            end
            held = out_valid && !out_ready;
            hd = out_data;
            if (in_valid && in_ready) sent++;
        end
        if (got < len) check("timeout_outputs", got, len);
        @(negedge clk);
        in_valid = 1'b0;
        coef_we = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1; coef_we = 0; coef_idx = 0; coef_data = 0; pad_mode = 0;
        in_valid = 0; in_data = 0; in_last = 0; out_ready = 1;
        mc = '{0, 0, 0};
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("idle_in_ready", in_ready, 1);
        write_coef(0, 1); write_coef(1, 2); write_coef(2, 1);
        for (int i = 0; i < 4; i++) xs[i] = i + 1;
        run_line(4, 0, 0, 0);
        check("drain_valid", out_valid, 0);
        check("drain_busy", busy, 0);
        run_line(4, 1, 0, 0);
        xs[0] = 10; xs[1] = 20; xs[2] = 30;
        run_line(3, 0, 0, 0);
        write_coef(0, 127); write_coef(1, 127); write_coef(2, 127);
        for (int i = 0; i < 3; i++) xs[i] = 127;
        run_line(3, 0, 0, 0);
        for (int i = 0; i < 3; i++) xs[i] = -128;
        run_line(3, 0, 0, 0);
        write_coef(0, 1); write_coef(1, 2); write_coef(2, 1);
        for (int i = 0; i < 4; i++) xs[i] = i + 1;
        run_line(4, 0, 60, 0);
        run_line(4, 0, 85, 0);
        xs[0] = 5;
        run_line(1, 0, 0, 1);
        for (int i = 0; i < 4; i++) xs[i] = i + 1;
        run_line(4, 0, 0, 0);
        write_coef(3, 99);
        run_line(4, 1, 0, 0);
        for (int it = 0; it < 20; it++) begin
            int len = $urandom_range(12, 1);
            int rps [3] = '{0, 30, 70};
            for (int j = 0; j < 3; j++) write_coef(j, $signed(8'($urandom)));
            if ($urandom_range(1) != 0) write_coef(3, $signed(8'($urandom)));
            for (int i = 0; i < len; i++) xs[i] = $signed(8'($urandom));
            run_line(len, $urandom_range(1), rps[$urandom_range(2)], $urandom_range(1) != 0);
        end
        write_coef(0, 1); write_coef(1, 2); write_coef(2, 1);
        @(negedge clk);
        pad_mode = 0; out_ready = 1; in_valid = 1; in_data = 8'd1; in_last = 0;
        @(negedge clk);
        in_data = 8'd2;
        @(negedge clk);
        in_valid = 0;
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_data", out_data, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_last", out_last, 0);
        @(negedge clk);
        rst = 1'b0;
        mc = '{0, 0, 0};
        for (int i = 0; i < 5; i++) xs[i] = i * 7 + 3;
        run_line(5, 0, 0, 0);
        write_coef(0, 1); write_coef(1, 2); write_coef(2, 1);
        for (int i = 0; i < 4; i++) xs[i] = i + 1;
        run_line(4, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
